// File: rtl/params_pkg.sv
// Shared defaults and the ROB entry record for multi_commit_rob and its commit scanner.
package params_pkg;
    localparam int REGISTER_WIDTH = 5;
    localparam int ROB_ENTRIES    = 8;
    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;

    typedef struct packed {
        logic                      allocated;
        logic                      done;
        logic                      excp;
        logic                      wb;
        logic [REGISTER_WIDTH-1:0] reg_id;
        logic [ADDR_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     data;
    } rob_entry_t;
endpackage

// File: rtl/rob_commit_scan.sv
// Combinational retire scan: longest in-order run of clean completed entries from head,
// plus the exception flush condition on the head entry.
module rob_commit_scan #(
    parameter  int ROB_ENTRIES  = 8,
    parameter  int COMMIT_WIDTH = 2,
    localparam int EW           = $clog2(ROB_ENTRIES),
    localparam int CW           = EW + 1
) (
    input  logic [ROB_ENTRIES-1:0]  i_alloc,
    input  logic [ROB_ENTRIES-1:0]  i_done,
    input  logic [ROB_ENTRIES-1:0]  i_excp,
    input  logic [EW-1:0]           i_head,
    output logic [COMMIT_WIDTH-1:0] o_slot_vld,
    output logic [CW-1:0]           o_retire_cnt,
    output logic                    o_flush
);
    logic [COMMIT_WIDTH-1:0] w_ok;
    logic                    w_run;

    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_ok
        logic [EW-1:0] w_idx;
        assign w_idx   = i_head + EW'(k);
        assign w_ok[k] = i_alloc[w_idx] & i_done[w_idx] & ~i_excp[w_idx];
    end

    // Slots form a prefix: the first non-retirable entry stops the run.
    always_comb begin
        w_run        = 1'b1;
        o_slot_vld   = '0;
        o_retire_cnt = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            w_run         = w_run & w_ok[k];
            o_slot_vld[k] = w_run;
            o_retire_cnt  = o_retire_cnt + CW'(w_run);
        end
    end

    assign o_flush = i_alloc[i_head] & i_done[i_head] & i_excp[i_head];
endmodule

// File: rtl/multi_commit_rob.sv
// Reorder buffer with multi-port completion and up to COMMIT_WIDTH in-order retirements per cycle.
// Optional macro ROB_COMMIT_TRACE_EN adds commit_pc_o with each retiring slot's PC.
module multi_commit_rob #(
    parameter  int REGISTER_WIDTH  = params_pkg::REGISTER_WIDTH,
    parameter  int ROB_ENTRIES     = params_pkg::ROB_ENTRIES,
    parameter  int ADDR_WIDTH      = params_pkg::ADDR_WIDTH,
    parameter  int DATA_WIDTH      = params_pkg::DATA_WIDTH,
    parameter  int COMMIT_WIDTH    = 2,
    parameter  int CPL_PORTS       = 2,
    localparam int ROB_ENTRY_WIDTH = $clog2(ROB_ENTRIES),
    localparam int CNT_WIDTH       = ROB_ENTRY_WIDTH + 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        alloc_valid_i,
    input  logic                                        alloc_is_wb_i,
    input  logic [REGISTER_WIDTH-1:0]                   alloc_reg_id_i,
    input  logic [ADDR_WIDTH-1:0]                       alloc_pc_i,
    output logic                                        alloc_ready_o,
    output logic [ROB_ENTRY_WIDTH-1:0]                  alloc_idx_o,
    input  logic [CPL_PORTS-1:0]                        cpl_valid_i,
    input  logic [CPL_PORTS-1:0][ROB_ENTRY_WIDTH-1:0]   cpl_idx_i,
    input  logic [CPL_PORTS-1:0][DATA_WIDTH-1:0]        cpl_data_i,
    input  logic [CPL_PORTS-1:0]                        cpl_excp_i,
    output logic [COMMIT_WIDTH-1:0]                     commit_valid_o,
    output logic [COMMIT_WIDTH-1:0]                     commit_is_wb_o,
    output logic [COMMIT_WIDTH-1:0][REGISTER_WIDTH-1:0] commit_reg_id_o,
    output logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]     commit_data_o,
    output logic                                        flush_o,
    output logic [ADDR_WIDTH-1:0]                       flush_pc_o,
    output logic [CNT_WIDTH-1:0]                        count_o,
    output logic                                        empty_o
`ifdef ROB_COMMIT_TRACE_EN
   ,output logic [COMMIT_WIDTH-1:0][ADDR_WIDTH-1:0]     commit_pc_o
`endif
);
    import params_pkg::*;

    rob_entry_t                                r_rob [ROB_ENTRIES];
    logic [ROB_ENTRY_WIDTH-1:0]                r_head;
    logic [ROB_ENTRY_WIDTH-1:0]                r_tail;
    logic [CNT_WIDTH-1:0]                      r_count;

    logic [ROB_ENTRIES-1:0]                    w_alloc;
    logic [ROB_ENTRIES-1:0]                    w_done;
    logic [ROB_ENTRIES-1:0]                    w_excp;
    logic [COMMIT_WIDTH-1:0]                   w_slot_vld;
    logic [COMMIT_WIDTH-1:0][ROB_ENTRY_WIDTH-1:0] w_slot_idx;
    logic [CNT_WIDTH-1:0]                      w_retire;
    logic                                      w_flush;
    logic                                      w_alloc_fire;

    always_comb begin
        w_alloc = '0;
        w_done  = '0;
        w_excp  = '0;
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            w_alloc[i] = r_rob[i].allocated;
            w_done[i]  = r_rob[i].done;
            w_excp[i]  = r_rob[i].excp;
        end
    end

    rob_commit_scan #(
        .ROB_ENTRIES  (ROB_ENTRIES),
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_scan (
        .i_alloc      (w_alloc),
        .i_done       (w_done),
        .i_excp       (w_excp),
        .i_head       (r_head),
        .o_slot_vld   (w_slot_vld),
        .o_retire_cnt (w_retire),
        .o_flush      (w_flush)
    );

    // Ready uses the registered count, so a full ROB never allocates even while retiring.
    assign alloc_ready_o = (r_count < CNT_WIDTH'(ROB_ENTRIES)) && !w_flush;
    assign alloc_idx_o   = r_tail;
    assign w_alloc_fire  = alloc_valid_i && alloc_ready_o;
    assign flush_o       = w_flush;
    assign flush_pc_o    = w_flush ? r_rob[r_head].pc : '0;
    assign count_o       = r_count;
    assign empty_o       = (r_count == '0);
    assign commit_valid_o = w_slot_vld;

    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_slot
        assign w_slot_idx[k]      = r_head + ROB_ENTRY_WIDTH'(k);
        assign commit_is_wb_o[k]  = w_slot_vld[k] & r_rob[w_slot_idx[k]].wb;
        assign commit_reg_id_o[k] = w_slot_vld[k] ? r_rob[w_slot_idx[k]].reg_id : '0;
        assign commit_data_o[k]   = w_slot_vld[k] ? r_rob[w_slot_idx[k]].data : '0;
`ifdef ROB_COMMIT_TRACE_EN
        assign commit_pc_o[k]     = w_slot_vld[k] ? r_rob[w_slot_idx[k]].pc : '0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) r_rob[i] <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                r_rob[i].allocated <= 1'b0;
                r_rob[i].done      <= 1'b0;
                r_rob[i].excp      <= 1'b0;
            end
        end else begin
            // Descending port order so the lowest-numbered port's write lands last.
            for (int p = CPL_PORTS - 1; p >= 0; p--) begin
                if (cpl_valid_i[p] && r_rob[cpl_idx_i[p]].allocated) begin
                    r_rob[cpl_idx_i[p]].done <= 1'b1;
                    r_rob[cpl_idx_i[p]].excp <= cpl_excp_i[p];
                    r_rob[cpl_idx_i[p]].data <= cpl_data_i[p];
                end
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (w_slot_vld[k]) begin
                    r_rob[w_slot_idx[k]].allocated <= 1'b0;
                    r_rob[w_slot_idx[k]].done      <= 1'b0;
                end
            end
            if (w_alloc_fire) begin
                r_rob[r_tail].allocated <= 1'b1;
                r_rob[r_tail].done      <= 1'b0;
                r_rob[r_tail].excp      <= 1'b0;
                r_rob[r_tail].wb        <= alloc_is_wb_i;
                r_rob[r_tail].reg_id    <= alloc_reg_id_i;
                r_rob[r_tail].pc        <= alloc_pc_i;
            end
            r_head  <= r_head + w_retire[ROB_ENTRY_WIDTH-1:0];
            r_tail  <= r_tail + ROB_ENTRY_WIDTH'(w_alloc_fire);
            r_count <= r_count + CNT_WIDTH'(w_alloc_fire) - w_retire;
        end
    end
endmodule

// File: tb/tb_multi_commit_rob.sv
// Bench for multi_commit_rob: directed scenarios plus random traffic against a queue-based model.
module tb_multi_commit_rob;
    localparam int N   = 8;
    localparam int EW  = 3;
    localparam int CNW = 4;
    localparam int CW  = 2;
    localparam int CP  = 2;
    localparam int RW  = 5;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int OBSW = 1 + EW + CNW + 1 + 1 + AW + CW + CW + CW*RW + CW*DW;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   a_v, a_wb;
    logic [RW-1:0]          a_reg;
    logic [AW-1:0]          a_pc;
    logic                   alloc_ready_o;
    logic [EW-1:0]          alloc_idx_o;
    logic [CP-1:0]          c_v;
    logic [CP-1:0][EW-1:0]  c_idx;
    logic [CP-1:0][DW-1:0]  c_data;
    logic [CP-1:0]          c_ex;
    logic [CW-1:0]          commit_valid_o, commit_is_wb_o;
    logic [CW-1:0][RW-1:0]  commit_reg_id_o;
    logic [CW-1:0][DW-1:0]  commit_data_o;
    logic                   flush_o;
    logic [AW-1:0]          flush_pc_o;
    logic [CNW-1:0]         count_o;
    logic                   empty_o;

    always #5 clk_i = ~clk_i;

    multi_commit_rob #(
        .REGISTER_WIDTH(RW), .ROB_ENTRIES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .COMMIT_WIDTH(CW), .CPL_PORTS(CP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alloc_valid_i(a_v), .alloc_is_wb_i(a_wb), .alloc_reg_id_i(a_reg), .alloc_pc_i(a_pc),
        .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
        .cpl_valid_i(c_v), .cpl_idx_i(c_idx), .cpl_data_i(c_data), .cpl_excp_i(c_ex),
        .commit_valid_o(commit_valid_o), .commit_is_wb_o(commit_is_wb_o),
        .commit_reg_id_o(commit_reg_id_o), .commit_data_o(commit_data_o),
        .flush_o(flush_o), .flush_pc_o(flush_pc_o), .count_o(count_o), .empty_o(empty_o)
    );

    // Model: the ROB is a program-order queue; head is m_q[0].
    typedef struct {
        int            idx;
        bit            wb;
        logic [RW-1:0] rid;
        logic [AW-1:0] pc;
        bit            done;
        bit            excp;
        logic [DW-1:0] data;
    } ment_t;
    ment_t m_q[$];
    int    m_tail;

    logic                  e_ready, e_empty, e_flush;
    logic [EW-1:0]         e_idx;
    logic [CNW-1:0]        e_count;
    logic [AW-1:0]         e_fpc;
    logic [CW-1:0]         e_cv, e_cwb;
    logic [CW-1:0][RW-1:0] e_creg;
    logic [CW-1:0][DW-1:0] e_cdata;

    int n_run  = 0;
    int n_fail = 0;

    function automatic void predict();
        int n   = m_q.size();
        bit run = 1'b1;
        e_cv = '0; e_cwb = '0; e_creg = '0; e_cdata = '0;
        e_flush = (n > 0) && m_q[0].done && m_q[0].excp;
        e_fpc   = e_flush ? m_q[0].pc : '0;
        for (int k = 0; k < CW; k++) begin
            if (run && k < n && m_q[k].done && !m_q[k].excp) begin
                e_cv[k]    = 1'b1;
                e_cwb[k]   = m_q[k].wb;
                e_creg[k]  = m_q[k].rid;
                e_cdata[k] = m_q[k].data;
            end else run = 1'b0;
        end
        e_ready = (n < N) && !e_flush;
        e_idx   = EW'(m_tail);
        e_count = CNW'(n);
        e_empty = (n == 0);
    endfunction

    function automatic logic [OBSW-1:0] obs_vec();
        return {alloc_ready_o, alloc_idx_o, count_o, empty_o, flush_o, flush_pc_o,
                commit_valid_o, commit_is_wb_o, commit_reg_id_o, commit_data_o};
    endfunction

    function automatic logic [OBSW-1:0] exp_vec();
        predict();
        return {e_ready, e_idx, e_count, e_empty, e_flush, e_fpc, e_cv, e_cwb, e_creg, e_cdata};
    endfunction

    task automatic clr_inputs();
        a_v = 0; a_wb = 0; a_reg = '0; a_pc = '0;
        c_v = '0; c_idx = '0; c_data = '0; c_ex = '0;
    endtask

    // Advance DUT and model across one rising edge; returns at the following falling edge.
    task automatic tick();
        predict();
        @(posedge clk_i);
        if (e_flush) begin
            m_q.delete();
            m_tail = 0;
        end else begin
            for (int p = CP - 1; p >= 0; p--)
                if (c_v[p])
                    for (int i = 0; i < m_q.size(); i++)
                        if (m_q[i].idx == int'(c_idx[p])) begin
                            m_q[i].done = 1; m_q[i].excp = c_ex[p]; m_q[i].data = c_data[p];
                        end
            for (int k = 0; k < CW; k++) if (e_cv[k]) void'(m_q.pop_front());
            if (a_v && e_ready) begin
                m_q.push_back('{idx: m_tail, wb: a_wb, rid: a_reg, pc: a_pc, done: 0, excp: 0, data: '0});
                m_tail = (m_tail + 1) % N;
            end
        end
        @(negedge clk_i);
        clr_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 0;
        clr_inputs();
        m_q.delete();
        m_tail = 0;
        @(negedge clk_i);
        rst_i = 1;
    endtask

    task automatic alloc_n(input int n, input int pc0);
        for (int i = 0; i < n; i++) begin
            a_v = 1; a_wb = 1; a_reg = RW'(i + 1); a_pc = AW'(pc0 + 4 * i);
            tick();
        end
    endtask

    task automatic test_reset();
        #1;
        n_run++;
        if (obs_vec() !== exp_vec() || alloc_ready_o !== 1'b1 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", obs_vec(), exp_vec());
        end
        @(negedge clk_i);
        rst_i = 1;
        #1;
        n_run++;
        if (count_o !== '0 || commit_valid_o !== '0 || flush_o !== 1'b0 || flush_pc_o !== '0 || alloc_idx_o !== '0) begin
            n_fail++;
            $display("FAIL reset_release got cnt=%0d cv=%b fl=%b", count_o, commit_valid_o, flush_o);
        end
    endtask

    task automatic test_in_order();
        int            order[3] = '{2, 0, 1};
        logic [RW-1:0] got[$];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if (alloc_idx_o !== EW'(i)) begin
                n_fail++;
                $display("FAIL inorder_alloc_idx got %0d want %0d", alloc_idx_o, i);
            end
            a_v = 1; a_wb = 1; a_reg = RW'(i + 1); a_pc = AW'(32'h100 + 4 * i);
            tick();
        end
        for (int j = 0; j < 6; j++) begin
            if (j < 3) begin
                c_v[0] = 1; c_idx[0] = EW'(order[j]); c_data[0] = DW'(32'h50 + order[j]);
            end
            for (int k = 0; k < CW; k++) if (commit_valid_o[k]) got.push_back(commit_reg_id_o[k]);
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL inorder_cycle%0d got %h want %h", j, obs_vec(), exp_vec());
            end
            tick();
        end
        n_run++;
        if (got.size() != 3 || got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3) begin
            n_fail++;
            $display("FAIL inorder_sequence got %0d commits want 3 in order 1,2,3", got.size());
        end
    endtask

    task automatic test_full();
        do_reset();
        alloc_n(8, 32'h300);
        n_run++;
        if (alloc_ready_o !== 1'b0 || count_o !== 4'd8) begin
            n_fail++;
            $display("FAIL full_state got ready=%b cnt=%0d want ready=0 cnt=8", alloc_ready_o, count_o);
        end
        c_v = 2'b11; c_idx[0] = 3'd0; c_idx[1] = 3'd1; c_data[0] = 32'h11; c_data[1] = 32'h22;
        tick();
        a_v = 1; a_wb = 1; a_reg = 5'd30; a_pc = 32'h400;
        n_run++;
        if (commit_valid_o !== 2'b11 || alloc_ready_o !== 1'b0 || commit_data_o[1] !== 32'h22) begin
            n_fail++;
            $display("FAIL full_retire got cv=%b ready=%b d1=%h want cv=11 ready=0 d1=22",
                     commit_valid_o, alloc_ready_o, commit_data_o[1]);
        end
        tick();
        n_run++;
        if (alloc_ready_o !== 1'b1 || count_o !== 4'd6) begin
            n_fail++;
            $display("FAIL full_ready_back got ready=%b cnt=%0d want ready=1 cnt=6", alloc_ready_o, count_o);
        end
    endtask

    task automatic test_same_idx();
        do_reset();
        alloc_n(6, 32'h500);
        for (int j = 0; j < 3; j++) begin
            c_v = (j < 2) ? 2'b11 : 2'b01;
            c_idx[0] = EW'(2 * j); c_idx[1] = EW'(2 * j + 1);
            c_data[0] = 32'h70; c_data[1] = 32'h71;
            tick();
        end
        repeat (3) tick();
        c_v = 2'b11; c_idx[0] = 3'd5; c_idx[1] = 3'd5; c_data[0] = 32'hA; c_data[1] = 32'hB;
        tick();
        n_run++;
        if (commit_valid_o !== 2'b01 || commit_data_o[0] !== 32'hA || commit_data_o[1] !== '0) begin
            n_fail++;
            $display("FAIL same_idx_priority got cv=%b d0=%h want cv=01 d0=a", commit_valid_o, commit_data_o[0]);
        end
    endtask

    task automatic test_exception();
        do_reset();
        alloc_n(2, 32'h200);
        c_v = 2'b11; c_idx[0] = 3'd0; c_idx[1] = 3'd1; c_data[0] = 32'h33; c_ex[1] = 1'b1;
        tick();
        n_run++;
        if (commit_valid_o !== 2'b01 || flush_o !== 1'b0 || commit_data_o[0] !== 32'h33) begin
            n_fail++;
            $display("FAIL excp_prior_commit got cv=%b fl=%b want cv=01 fl=0", commit_valid_o, flush_o);
        end
        a_v = 1; a_pc = 32'h999;
        tick();
        n_run++;
        if (flush_o !== 1'b1 || flush_pc_o !== 32'h204 || commit_valid_o !== '0 || alloc_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL excp_flush got fl=%b pc=%h cv=%b want fl=1 pc=204 cv=00", flush_o, flush_pc_o, commit_valid_o);
        end
        tick();
        n_run++;
        if (count_o !== '0 || empty_o !== 1'b1 || flush_o !== 1'b0 || alloc_idx_o !== '0) begin
            n_fail++;
            $display("FAIL excp_after got cnt=%0d empty=%b fl=%b want cnt=0 empty=1 fl=0", count_o, empty_o, flush_o);
        end
    endtask

    task automatic test_wrap();
        logic [RW-1:0] got[$];
        logic [CW-1:0] cv_at1;
        do_reset();
        alloc_n(6, 32'h600);
        for (int j = 0; j < 3; j++) begin
            c_v = 2'b11; c_idx[0] = EW'(2 * j); c_idx[1] = EW'(2 * j + 1);
            tick();
        end
        repeat (3) tick();
        n_run++;
        if (count_o !== '0 || alloc_idx_o !== 3'd6) begin
            n_fail++;
            $display("FAIL wrap_setup got cnt=%0d idx=%0d want cnt=0 idx=6", count_o, alloc_idx_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_run++;
            if (alloc_idx_o !== EW'((6 + i) % N)) begin
                n_fail++;
                $display("FAIL wrap_alloc_idx got %0d want %0d", alloc_idx_o, (6 + i) % N);
            end
            a_v = 1; a_wb = 1; a_reg = RW'(i); a_pc = AW'(32'h700 + 4 * i);
            tick();
        end
        cv_at1 = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < 2) begin
                c_v = 2'b11; c_idx[0] = EW'((6 + 2 * j) % N); c_idx[1] = EW'((7 + 2 * j) % N);
            end
            if (j == 1) cv_at1 = commit_valid_o;
            for (int k = 0; k < CW; k++) if (commit_valid_o[k]) got.push_back(commit_reg_id_o[k]);
            tick();
        end
        n_run++;
        if (cv_at1 !== 2'b11 || got.size() != 4 || got[0] !== 5'd0 || got[1] !== 5'd1 ||
            got[2] !== 5'd2 || got[3] !== 5'd3) begin
            n_fail++;
            $display("FAIL wrap_commit_order got cv=%b n=%0d want cv=11 n=4 order 0,1,2,3", cv_at1, got.size());
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        alloc_n(5, 32'h800);
        c_v = 2'b11; c_idx[0] = 3'd0; c_idx[1] = 3'd1;
        tick();
        #2;
        rst_i = 0;
        #1;
        n_run++;
        if (commit_valid_o !== '0 || count_o !== '0 || empty_o !== 1'b1 || flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop got cv=%b cnt=%0d fl=%b want cv=00 cnt=0 fl=0", commit_valid_o, count_o, flush_o);
        end
        m_q.delete();
        m_tail = 0;
        @(negedge clk_i);
        rst_i = 1;
        #1;
        n_run++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_midop_release got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            a_v = ($urandom_range(0, 9) < 6); a_wb = 1'($urandom);
            a_reg = RW'($urandom); a_pc = $urandom;
            for (int p = 0; p < CP; p++) begin
                c_v[p] = 1'($urandom);
                if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
                    c_idx[p] = EW'(m_q[$urandom_range(0, m_q.size() - 1)].idx);
                else
                    c_idx[p] = EW'($urandom);
                c_data[p] = $urandom;
                c_ex[p]   = ($urandom_range(0, 29) == 0);
            end
            #1;
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        rst_i = 0;
        clr_inputs();
        m_tail = 0;
        @(negedge clk_i);
        test_reset();
        test_in_order();
        test_full();
        test_same_idx();
        test_exception();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
